glyph_stream_render: RTL and testbench
======================================

// Module: glyph_stream_render
// PURPOSE
//  Parametrised glyph renderer for the LCD path. Accepts one character command, fetches its
//  bitmap rows from the glyph library, then streams scaled colour pixels to lcd_ctrl in raster
//  order over a valid/ready link. Adds per-command fg/bg colour, integer scale, a fetch
//  timeout and backpressure.
// PARAMETERS
//  GLYPH_W    24   glyph width in pixels (bits per library row, MSB = leftmost pixel)
//  GLYPH_H    40   glyph height in rows
//  COLOR_W    16   pixel colour width (RGB565 at default)
//  MAX_SCALE  4    largest scale factor supported; scale field width SW = $clog2(MAX_SCALE)
//  FETCH_TO   1024 FETCH-state timeout in cycles
// PORTS
//  pclk          in   1        pixel-domain clock
//  rst           in   1        asynchronous, active-high reset
//  cmd_valid     in   1        command present
//  cmd_ready     out  1        block can accept a command (high only in IDLE)
//  cmd_code      in   32       character code forwarded to library
//  cmd_fg        in   COLOR_W  colour for set glyph bits
//  cmd_bg        in   COLOR_W  colour for clear glyph bits
//  cmd_scale     in   SW       scale-1 (0 => 1x); values >= MAX_SCALE clamp to MAX_SCALE
//  lib_req       out  1        one-cycle fetch request to glyph library
//  lib_code      out  32       latched code, stable from lib_req until DRAW
//  lib_row_valid in   1        library row beat valid
//  lib_row_idx   in   $clog2(GLYPH_H)  row index of this beat
//  lib_row_data  in   GLYPH_W  row bitmap
//  lib_done      in   1        library finished sending rows
//  pix_valid     out  1        pixel beat valid
//  pix_ready     in   1        lcd_ctrl accepts pixel
//  pix_data      out  COLOR_W  pixel colour
//  pix_last      out  1        marks final pixel of glyph
//  done          out  1        one-cycle pulse: glyph finished (or aborted)
//  err_timeout   out  1        qualifies done: fetch timed out, no pixels drawn
// BEHAVIOUR
//  Reset: state=IDLE; row buffer, latched cmd, counters cleared; cmd_ready=0 during rst,
//   1 the first cycle after; lib_req, pix_valid, pix_last, done, err_timeout = 0.
//  FSM: IDLE -> FETCH -> DRAW -> DONE -> IDLE; FETCH -> DONE on timeout.
//  IDLE: cmd_ready=1. On cmd_valid&&cmd_ready latch code/fg/bg/scale, clear row buffer,
//   go FETCH; lib_req=1 for exactly the first FETCH cycle.
//  FETCH: each lib_row_valid writes buffer[lib_row_idx]<=lib_row_data; idx>=GLYPH_H ignored;
//   rows never received render as bg. lib_done -> DRAW next cycle (a row beat in the same
//   cycle as lib_done is still stored). Cycle counter reaching FETCH_TO with no lib_done ->
//   DONE with err_timeout=1.
//  DRAW: S=scale; emits GLYPH_W*S x GLYPH_H*S pixels, x fastest. Pixel (x,y) =
//   buffer[y/S][GLYPH_W-1-x/S] ? fg : bg, implemented with sub-counters (no dividers).
//   First pix_valid one cycle after entering DRAW. Beat transfers on pix_valid&&pix_ready;
//   while pix_valid&&!pix_ready, pix_data/pix_last hold. One beat/cycle when ready held
//   high. pix_last=1 only with final pixel; its transfer -> DONE.
//  DONE: done=1 one cycle (err_timeout=1 same cycle if aborted, else 0); -> IDLE.
//  cmd_valid outside IDLE is ignored (not latched); lib beats outside FETCH ignored.
//  Async rst mid-FETCH/DRAW: outputs drop to reset values immediately; no done pulse.
// TESTING
//  1 Reset, cmd code=0x41 fg=16'h0000 bg=16'hFFFF scale=0, rows 0..39 = 24'h800001, lib_done,
//     ready=1 -> 960 beats; beats x=0 and x=23 = 0000, others FFFF; pix_last on beat 960; done.
//  2 Same glyph, scale=1 -> 3840 beats, 48 per line; row 0 pixels 0,1,46,47 = fg; done once.
//  3 Scale=0, pix_ready toggled random 50% -> identical 960-pixel sequence to test 1,
//     pix_data stable on every stalled cycle.
//  4 Library never asserts lib_done -> after FETCH_TO cycles done=1 with err_timeout=1,
//     zero pix_valid beats, cmd_ready=1 next cycle.
//  5 Only rows 0 and 39 sent (24'hFFFFFF) plus a beat with idx=45 -> rows 1..38 all bg,
//     no corruption; cmd_valid pulsed during DRAW not accepted.
//  6 Assert rst at beat 500 of DRAW -> pix_valid=0 same cycle, no done; new cmd renders fully.

Source files
------------

// File: rtl/glyph_stream_render.sv
// Glyph renderer: latches one character command, collects its bitmap rows from the glyph
// library, then streams scaled fg/bg pixels in raster order over a valid/ready link.
module glyph_stream_render #(
  parameter int unsigned GLYPH_W   = 24,
  parameter int unsigned GLYPH_H   = 40,
  parameter int unsigned COLOR_W   = 16,
  parameter int unsigned MAX_SCALE = 4,
  parameter int unsigned FETCH_TO  = 1024,
  localparam int unsigned SW = (MAX_SCALE > 1) ? $clog2(MAX_SCALE) : 1,
  localparam int unsigned RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_code,
  input  logic [COLOR_W-1:0] cmd_fg,
  input  logic [COLOR_W-1:0] cmd_bg,
  input  logic [SW-1:0]      cmd_scale,
  output logic               lib_req,
  output logic [31:0]        lib_code,
  input  logic               lib_row_valid,
  input  logic [RW-1:0]      lib_row_idx,
  input  logic [GLYPH_W-1:0] lib_row_data,
  input  logic               lib_done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COLOR_W-1:0] pix_data,
  output logic               pix_last,
  output logic               done,
  output logic               err_timeout
);

  localparam int unsigned CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned TW = $clog2(FETCH_TO + 1);
  localparam logic [CW-1:0] ColLast   = CW'(GLYPH_W - 1);
  localparam logic [RW-1:0] RowLast   = RW'(GLYPH_H - 1);
  localparam logic [SW-1:0] ScaleMax  = SW'(MAX_SCALE - 1);
  localparam logic [TW-1:0] FetchLast = TW'(FETCH_TO - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDraw, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0]        code_q;
  logic [COLOR_W-1:0] fg_q, bg_q;
  logic [SW-1:0]      scale_q;  // scale factor minus one
  logic [GLYPH_W-1:0] buf_q [GLYPH_H];
  logic [TW-1:0]      fetch_cnt_q;
  logic               timeout_q;
  logic [SW-1:0]      x_sub_q, y_sub_q;
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      row_q;
  logic               pix_valid_q, pix_last_q;
  logic [COLOR_W-1:0] pix_data_q;

  logic accept, fetch_expire, load_pix, last_xfer;
  logic x_end, y_end, col_end, row_end, cur_bit;

  assign accept       = cmd_valid && cmd_ready;
  assign fetch_expire = (state_q == StFetch) && !lib_done && (fetch_cnt_q == FetchLast);
  // Refill the output register when empty or when its beat is leaving (except the last one).
  assign load_pix  = (state_q == StDraw) && (!pix_valid_q || (pix_ready && !pix_last_q));
  assign last_xfer = (state_q == StDraw) && pix_valid_q && pix_ready && pix_last_q;
  assign x_end     = (x_sub_q == scale_q);
  assign y_end     = (y_sub_q == scale_q);
  assign col_end   = (col_q == ColLast);
  assign row_end   = (row_q == RowLast);
  assign cur_bit   = buf_q[row_q][ColLast - col_q];

  assign lib_code  = code_q;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_last  = pix_last_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StFetch;
      StFetch: begin
        if (lib_done) begin
          state_d = StDraw;
        end else if (fetch_expire) begin
          state_d = StDone;
        end
      end
      StDraw:  if (last_xfer) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    lib_req     = 1'b0;
    done        = 1'b0;
    err_timeout = 1'b0;
    unique case (state_q)
      StIdle:  cmd_ready = !rst;
      StFetch: lib_req = (fetch_cnt_q == '0);
      StDone: begin
        done        = 1'b1;
        err_timeout = timeout_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      code_q      <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      scale_q     <= '0;
      fetch_cnt_q <= '0;
      timeout_q   <= 1'b0;
      x_sub_q     <= '0;
      y_sub_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_data_q  <= '0;
      for (int unsigned i = 0; i < GLYPH_H; i++) buf_q[i] <= '0;
    end else begin
      if (accept) begin
        code_q      <= cmd_code;
        fg_q        <= cmd_fg;
        bg_q        <= cmd_bg;
        scale_q     <= (cmd_scale > ScaleMax) ? ScaleMax : cmd_scale;
        fetch_cnt_q <= '0;
        timeout_q   <= 1'b0;
        x_sub_q     <= '0;
        y_sub_q     <= '0;
        col_q       <= '0;
        row_q       <= '0;
        for (int unsigned i = 0; i < GLYPH_H; i++) buf_q[i] <= '0;
      end
      if (state_q == StFetch) begin
        fetch_cnt_q <= fetch_cnt_q + TW'(1);
        if (lib_row_valid && (32'(lib_row_idx) < GLYPH_H)) begin
          buf_q[lib_row_idx] <= lib_row_data;
        end
        if (fetch_expire) timeout_q <= 1'b1;
      end
      if (load_pix) begin
        pix_valid_q <= 1'b1;
        pix_data_q  <= cur_bit ? fg_q : bg_q;
        pix_last_q  <= x_end && col_end && y_end && row_end;
        // x sub-pixel fastest, then column, then y sub-row, then glyph row.
        if (x_end) begin
          x_sub_q <= '0;
          if (col_end) begin
            col_q <= '0;
            if (y_end) begin
              y_sub_q <= '0;
              row_q   <= row_end ? '0 : row_q + RW'(1);
            end else begin
              y_sub_q <= y_sub_q + SW'(1);
            end
          end else begin
            col_q <= col_q + CW'(1);
          end
        end else begin
          x_sub_q <= x_sub_q + SW'(1);
        end
      end else if (last_xfer) begin
        pix_valid_q <= 1'b0;
        pix_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_glyph_stream_render.sv
// Bench for glyph_stream_render: a raster model built from the rows the bench sends is
// checked beat by beat, with directed scenarios for scale, stalls, timeout, sparse rows, reset.
module tb_glyph_stream_render;

  logic        pclk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_code, lib_code;
  logic [15:0] cmd_fg, cmd_bg, pix_data;
  logic [1:0]  cmd_scale;
  logic        lib_req, lib_row_valid, lib_done;
  logic [5:0]  lib_row_idx;
  logic [23:0] lib_row_data;
  logic        pix_valid, pix_ready, pix_last, done, err_timeout;

  glyph_stream_render dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_fg(cmd_fg), .cmd_bg(cmd_bg), .cmd_scale(cmd_scale),
    .lib_req(lib_req), .lib_code(lib_code), .lib_row_valid(lib_row_valid),
    .lib_row_idx(lib_row_idx), .lib_row_data(lib_row_data), .lib_done(lib_done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last), .done(done), .err_timeout(err_timeout)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int          total = 0, bad = 0;
  logic [23:0] mrows [40];
  logic [15:0] exp_mem [3840];
  int          exp_total = 0;
  int          beat_idx = 0, pv_cnt = 0, stall_cnt = 0;
  int          cyc = 0, lib_req_cyc = 0, done_cyc = 0, done_cnt = 0, lib_req_cnt = 0;
  bit          done_err = 1'b0;
  bit          stalled = 1'b0;
  bit          ready_rand = 1'b0;
  logic [15:0] held_data;
  logic        held_last;
  logic [15:0] cap [48];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected raster straight from the definition: pixel (x,y) = row[y/S] bit (23 - x/S).
  task automatic build_expected(input logic [15:0] fg, input logic [15:0] bg, input int s);
    logic [23:0] r;
    exp_total = 24 * s * 40 * s;
    for (int y = 0; y < 40 * s; y++) begin
      r = mrows[y / s];
      for (int x = 0; x < 24 * s; x++) exp_mem[y * 24 * s + x] = r[23 - x / s] ? fg : bg;
    end
  endtask

  task automatic monitor();
    cyc++;
    if (rst) begin
      stalled  = 1'b0;
      beat_idx = 0;
      check_eq("rst_pix_valid", pix_valid, 0);
      check_eq("rst_done", done, 0);
      return;
    end
    if (lib_req) begin
      lib_req_cnt++;
      lib_req_cyc = cyc;
      beat_idx    = 0;
      pv_cnt      = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err_timeout;
    end
    if (pix_valid) begin
      pv_cnt++;
      if (stalled) begin
        check_eq("stall_data", pix_data, held_data);
        check_eq("stall_last", pix_last, held_last);
      end
      if (pix_ready) begin
        stalled = 1'b0;
        total++;
        if (beat_idx >= exp_total) begin
          bad++;
          $display("FAIL extra_beat idx=%0d got data=%h", beat_idx, pix_data);
        end else if (pix_data !== exp_mem[beat_idx] ||
                     pix_last !== (beat_idx == exp_total - 1)) begin
          bad++;
          $display("FAIL pix_beat idx=%0d got data=%h last=%b want data=%h last=%b", beat_idx,
                   pix_data, pix_last, exp_mem[beat_idx], (beat_idx == exp_total - 1));
        end
        if (beat_idx < 48) cap[beat_idx] = pix_data;
        beat_idx++;
      end else begin
        stalled = 1'b1;
        stall_cnt++;
        held_data = pix_data;
        held_last = pix_last;
      end
    end else begin
      if (stalled) begin
        total++;
        bad++;
        $display("FAIL stall_drop: got pix_valid=0 want 1 at beat %0d", beat_idx);
      end
      stalled = 1'b0;
    end
  endtask

  // Sample at the falling edge, then return 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge pclk);
    monitor();
    @(posedge pclk);
    #1;
    if (ready_rand) pix_ready = 1'($urandom_range(0, 1));
  endtask

  // mode 0: all 40 rows, 1: rows 0 and 39 plus an out-of-range beat, 2: library silent
  task automatic start_cmd(input logic [31:0] code, input logic [15:0] fg, input logic [15:0] bg,
                           input logic [1:0] sc, input int mode);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("cmd_ready_wait", n < 50, 1);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_fg    = fg;
    cmd_bg    = bg;
    cmd_scale = sc;
    tick();
    cmd_valid = 1'b0;
    cmd_code  = 32'hDEAD_BEEF;
    cmd_fg    = 16'h5555;
    cmd_bg    = 16'hAAAA;
    check_eq("lib_req_first", lib_req, 1);
    check_eq("lib_code", lib_code, code);
    if (mode == 0) begin
      for (int r = 0; r < 40; r++) begin
        lib_row_valid = 1'b1;
        lib_row_idx   = 6'(r);
        lib_row_data  = mrows[r];
        lib_done      = (r == 39);
        tick();
        if (r == 0) check_eq("lib_req_once", lib_req, 0);
      end
    end else if (mode == 1) begin
      lib_row_valid = 1'b1;
      lib_row_idx   = 6'd0;
      lib_row_data  = mrows[0];
      tick();
      check_eq("lib_req_once", lib_req, 0);
      lib_row_idx  = 6'd45;
      lib_row_data = 24'h5A5A5A;
      tick();
      lib_row_idx  = 6'd39;
      lib_row_data = mrows[39];
      lib_done     = 1'b1;
      tick();
    end else begin
      tick();
      check_eq("lib_req_once", lib_req, 0);
    end
    check_eq("lib_code_hold", lib_code, code);
    lib_row_valid = 1'b0;
    lib_done      = 1'b0;
    lib_row_data  = '0;
    lib_row_idx   = '0;
  endtask

  task automatic wait_done(input bit pulse);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 20000) begin
      if (pulse && n == 20) begin
        check_eq("cmd_ready_in_draw", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_code  = 32'h99;
        cmd_fg    = 16'h1234;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    check_eq("done_seen", done_cnt - d0, 1);
    check_eq("cmd_ready_after_done", cmd_ready, 1);
    check_eq("done_one_cycle", done, 0);
  endtask

  int d0, lr0, n;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_code = '0; cmd_fg = '0; cmd_bg = '0; cmd_scale = '0;
    lib_row_valid = 1'b0; lib_row_idx = '0; lib_row_data = '0; lib_done = 1'b0;
    pix_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_lib_req", lib_req, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("rst_pix_last", pix_last, 0);
    rst = 1'b0;
    tick();
    check_eq("cmd_ready_after_rst", cmd_ready, 1);

    // 1: 1x glyph, left and right edge set
    for (int r = 0; r < 40; r++) mrows[r] = 24'h800001;
    build_expected(16'h0000, 16'hFFFF, 1);
    d0 = done_cnt;
    start_cmd(32'h41, 16'h0000, 16'hFFFF, 2'd0, 0);
    wait_done(1'b0);
    check_eq("t1_beats", beat_idx, 960);
    check_eq("t1_err", done_err, 0);
    check_eq("t1_x0", cap[0], 16'h0000);
    check_eq("t1_x1", cap[1], 16'hFFFF);
    check_eq("t1_x22", cap[22], 16'hFFFF);
    check_eq("t1_x23", cap[23], 16'h0000);
    tick();
    tick();
    check_eq("t1_done_once", done_cnt - d0, 1);

    // 2: same glyph at 2x
    build_expected(16'h0000, 16'hFFFF, 2);
    d0 = done_cnt;
    start_cmd(32'h41, 16'h0000, 16'hFFFF, 2'd1, 0);
    wait_done(1'b0);
    check_eq("t2_beats", beat_idx, 3840);
    check_eq("t2_x0", cap[0], 16'h0000);
    check_eq("t2_x1", cap[1], 16'h0000);
    check_eq("t2_x2", cap[2], 16'hFFFF);
    check_eq("t2_x45", cap[45], 16'hFFFF);
    check_eq("t2_x46", cap[46], 16'h0000);
    check_eq("t2_x47", cap[47], 16'h0000);
    tick();
    tick();
    check_eq("t2_done_once", done_cnt - d0, 1);

    // 3: 1x with random backpressure
    build_expected(16'h0000, 16'hFFFF, 1);
    stall_cnt = 0;
    start_cmd(32'h41, 16'h0000, 16'hFFFF, 2'd0, 0);
    ready_rand = 1'b1;
    wait_done(1'b0);
    ready_rand = 1'b0;
    pix_ready  = 1'b1;
    check_eq("t3_beats", beat_idx, 960);
    check_eq("t3_stalls_seen", stall_cnt > 0, 1);

    // 4: library never finishes
    exp_total = 0;
    start_cmd(32'h42, 16'h0000, 16'hFFFF, 2'd0, 2);
    wait_done(1'b0);
    check_eq("t4_timeout_cycles", done_cyc - lib_req_cyc, 1024);
    check_eq("t4_err", done_err, 1);
    check_eq("t4_no_pixels", pv_cnt, 0);

    // 5: sparse rows, out-of-range row beat, command pulse while drawing
    for (int r = 0; r < 40; r++) mrows[r] = 24'h000000;
    mrows[0]  = 24'hFFFFFF;
    mrows[39] = 24'hFFFFFF;
    build_expected(16'h07E0, 16'h0000, 1);
    lr0 = lib_req_cnt;
    start_cmd(32'h43, 16'h07E0, 16'h0000, 2'd0, 1);
    wait_done(1'b1);
    check_eq("t5_beats", beat_idx, 960);
    check_eq("t5_row0", cap[0], 16'h07E0);
    check_eq("t5_row1", cap[30], 16'h0000);
    check_eq("t5_one_fetch", lib_req_cnt - lr0, 1);
    check_eq("t5_err", done_err, 0);

    // 6: reset in the middle of drawing, then a clean glyph
    for (int r = 0; r < 40; r++) mrows[r] = 24'h800001;
    build_expected(16'h0000, 16'hFFFF, 1);
    start_cmd(32'h44, 16'h0000, 16'hFFFF, 2'd0, 0);
    n = 0;
    while (beat_idx < 500 && n < 5000) begin
      tick();
      n++;
    end
    check_eq("t6_reached_500", beat_idx >= 500, 1);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    check_eq("t6_pix_valid_drop", pix_valid, 0);
    check_eq("t6_done_low", done, 0);
    check_eq("t6_cmd_ready_in_rst", cmd_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("t6_cmd_ready_after", cmd_ready, 1);
    tick();
    check_eq("t6_no_done", done_cnt - d0, 0);
    for (int r = 0; r < 40; r++) mrows[r] = 24'(r * 24'h050301) ^ 24'hA00005;
    build_expected(16'hF800, 16'h001F, 1);
    start_cmd(32'h45, 16'hF800, 16'h001F, 2'd0, 0);
    wait_done(1'b0);
    check_eq("t6_beats", beat_idx, 960);
    check_eq("t6_err", done_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
